// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter, shifts a loaded word out on dout one bit per clock.
// Define SEQ_GEN_LOOP_EN to add the loop port that repeats the stored word.
module seq_gen #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
`ifdef SEQ_GEN_LOOP_EN
    input  logic             loop,
`endif
    output logic             ready,
    output logic             dout,
    output logic             dout_vld,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SEND, LAST} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sr, sr_n, word, shifted;
    logic [CW-1:0] cnt, cnt_n;
    logic accept, restart, start, dout_n;
`ifdef SEQ_GEN_LOOP_EN
    logic [WIDTH-1:0] stored;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stored <= '0;
        else if (accept) stored <= data;
`endif
    always_comb begin
        ready   = state != SEND;
        accept  = load && ready;
`ifdef SEQ_GEN_LOOP_EN
        restart = loop && state == LAST && !load;
        word    = accept ? data : stored;
`else
        restart = 1'b0;
        word    = data;
`endif
        start   = accept || restart;
        shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        sr_n    = start ? word : state == SEND ? shifted : sr;
        cnt_n   = start ? '0 : state == SEND ? cnt + CW'(1) : cnt;
        state_n = start ? SEND : state == SEND ? (cnt == CW'(WIDTH-2) ? LAST : SEND) : IDLE;
        // the bit leaving next cycle sits at the output end of the updated shift register
        dout_n  = state_n == IDLE ? IDLE_LEVEL : MSB_FIRST ? sr_n[WIDTH-1] : sr_n[0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            dout     <= IDLE_LEVEL;
            dout_vld <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            cnt      <= cnt_n;
            dout     <= dout_n;
            dout_vld <= state_n != IDLE;
            done     <= state_n == LAST;
        end
    end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed vector table, hand-written corner sequences and a queue-based random reference.
module tb_seq_gen;
    logic clk = 1'b0, rst_n = 1'b1, load = 1'b0, loop = 1'b0, load_l = 1'b0;
    logic [7:0] data = '0, data_l = '0;
    logic ready, dout, dout_vld, done, ready_l, dout_l, vld_l, done_l;
    int checks = 0, fails = 0;
    always #5 clk = ~clk;

    seq_gen #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data),
`ifdef SEQ_GEN_LOOP_EN
        .loop(loop),
`endif
        .ready(ready), .dout(dout), .dout_vld(dout_vld), .done(done));

    seq_gen #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .load(load_l), .data(data_l),
`ifdef SEQ_GEN_LOOP_EN
        .loop(1'b0),
`endif
        .ready(ready_l), .dout(dout_l), .dout_vld(vld_l), .done(done_l));

    typedef struct { logic ld; logic [7:0] d; logic o, vl, dn, rd; } vec_t;
    vec_t tv[$];
    bit mq[$];
    logic [7:0] mstored = '0;

    function automatic vec_t v(logic ld, logic [7:0] d, logic o, logic vl, logic dn, logic rd);
        return '{ld, d, o, vl, dn, rd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: queue of the frame bits still to appear, head is the current dout
    task automatic push_word(input logic [7:0] w);
        mq.delete();
        for (int i = 7; i >= 0; i--) mq.push_back(w[i]);
    endtask

    task automatic tick();
        logic loop_on;
        @(posedge clk);
`ifdef SEQ_GEN_LOOP_EN
        loop_on = loop;
`else
        loop_on = 1'b0;
`endif
        if (!rst_n) mq.delete();
        else if (load && mq.size() <= 1) begin
            push_word(data);
            mstored = data;
        end else if (mq.size() == 1 && loop_on) push_word(mstored);
        else if (mq.size() > 0) void'(mq.pop_front());
        @(negedge clk);
    endtask

    task automatic chk_model(input string name);
        chk({name, "_dout"}, dout, mq.size() > 0 ? mq[0] : 1'b0);
        chk({name, "_vld"}, dout_vld, mq.size() > 0);
        chk({name, "_done"}, done, mq.size() == 1);
        chk({name, "_ready"}, ready, mq.size() <= 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] lsb_exp, w81, w05;
        lsb_exp = 8'b1011_0000;
        w81 = 8'h81;
        w05 = 8'h05;
        // A6 MSB first with an ignored load of FF mid-frame
        tv.push_back(v(1, 8'hA6, 1, 1, 0, 0)); tv.push_back(v(0, 8'h00, 0, 1, 0, 0));
        tv.push_back(v(1, 8'hFF, 1, 1, 0, 0)); tv.push_back(v(0, 8'h00, 0, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 0, 1, 0, 0)); tv.push_back(v(0, 8'h00, 1, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 1, 1, 0, 0)); tv.push_back(v(0, 8'h00, 0, 1, 1, 1));
        tv.push_back(v(0, 8'h00, 0, 0, 0, 1));
        // A5 then 3C loaded in the last-bit cycle
        tv.push_back(v(1, 8'hA5, 1, 1, 0, 0)); tv.push_back(v(0, 8'h00, 0, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 1, 1, 0, 0)); tv.push_back(v(0, 8'h00, 0, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 0, 1, 0, 0)); tv.push_back(v(0, 8'h00, 1, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 0, 1, 0, 0)); tv.push_back(v(0, 8'h00, 1, 1, 1, 1));
        tv.push_back(v(1, 8'h3C, 0, 1, 0, 0)); tv.push_back(v(0, 8'h00, 0, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 1, 1, 0, 0)); tv.push_back(v(0, 8'h00, 1, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 1, 1, 0, 0)); tv.push_back(v(0, 8'h00, 1, 1, 0, 0));
        tv.push_back(v(0, 8'h00, 0, 1, 0, 0)); tv.push_back(v(0, 8'h00, 0, 1, 1, 1));
        tv.push_back(v(0, 8'h00, 0, 0, 0, 1));

        #3 rst_n = 1'b0;
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_dout", dout, 1'b0);
        chk("rst_vld", dout_vld, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            load = tv[i].ld;
            data = tv[i].d;
            tick();
            chk($sformatf("vec%0d_dout", i), dout, tv[i].o);
            chk($sformatf("vec%0d_vld", i), dout_vld, tv[i].vl);
            chk($sformatf("vec%0d_done", i), done, tv[i].dn);
            chk($sformatf("vec%0d_ready", i), ready, tv[i].rd);
        end
        load = 1'b0;

        // reset at bit 4 of F0, then a clean 81 frame
        load = 1'b1; data = 8'hF0; tick(); load = 1'b0;
        repeat (4) tick();
        chk("mid_vld_before", dout_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_dout", dout, 1'b0);
        chk("mid_rst_vld", dout_vld, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b1; data = 8'h81; tick(); load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("f81_dout%0d", k), dout, w81[7-k]);
            chk($sformatf("f81_done%0d", k), done, k == 7);
            tick();
        end
        chk("f81_idle", dout_vld, 1'b0);

        // LSB-first instance
        load_l = 1'b1; data_l = 8'h0D; tick(); load_l = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lsb_dout%0d", k), dout_l, lsb_exp[7-k]);
            chk($sformatf("lsb_done%0d", k), done_l, k == 7);
            chk($sformatf("lsb_ready%0d", k), ready_l, k == 7);
            tick();
        end
        chk("lsb_idle", vld_l, 1'b0);

`ifdef SEQ_GEN_LOOP_EN
        loop = 1'b1; load = 1'b1; data = w05; tick(); load = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("loop%0d_dout%0d", r, k), dout, w05[7-k]);
                chk($sformatf("loop%0d_done%0d", r, k), done, k == 7);
                chk($sformatf("loop%0d_vld%0d", r, k), dout_vld, 1'b1);
                if (r == 2 && k == 3) loop = 1'b0;
                tick();
            end
        chk("loop_end_vld", dout_vld, 1'b0);
        chk("loop_end_ready", ready, 1'b1);
`endif

        for (int c = 0; c < 400; c++) begin
            load = $urandom_range(0, 3) == 0;
            data = 8'($urandom);
`ifdef SEQ_GEN_LOOP_EN
            loop = $urandom_range(0, 3) != 0;
`endif
            tick();
            chk($sformatf("rnd%0d", c), 32'd0, 32'd0 + (dout_vld & ~dout_vld));
            chk_model($sformatf("rnd%0d", c));
        end
        load = 1'b0;
        loop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: accepts a parallel word over a load/ready handshake and shifts it out one bit per clock on `dout`. It drives the serial bit stream consumed by the team's serial sequence detectors, both in the bench and on-chip as a pattern source. `dout` changes only on the rising edge of `clk`, so it is stable at the falling-edge sampling point those detectors use.

## Interface
- `WIDTH`, 8: word length in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `dout` when no frame is active.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  request to transmit `data`; accepted only when `ready`=1.
- `data`  in  WIDTH  word to transmit; sampled on the accepting edge only.
- `loop`  in  1  repeat the stored word; present only with `SEQ_GEN_LOOP_EN`.
- `ready`  out  1  block can accept a load this cycle.
- `dout`  out  1  serial data, registered.
- `dout_vld`  out  1  `dout` carries a frame bit this cycle, registered.
- `done`  out  1  one-cycle pulse on the last bit of a frame, registered.

## Operation
- Storage: `WIDTH`-bit shift register, bit counter of $clog2(WIDTH) bits, and a `WIDTH`-bit copy of the accepted word (copy only with `SEQ_GEN_LOOP_EN`).
- States:
  - IDLE: `ready`=1, `dout`=IDLE_LEVEL, `dout_vld`=0.
  - SEND: bits 0..WIDTH-2 of the frame; `ready`=0.
  - LAST: final bit of the frame; `ready`=1, `done`=1.
- Transitions:
  - IDLE: `load` → SEND; otherwise stay in IDLE.
  - SEND: counter reaches WIDTH-2 → LAST.
  - LAST with `load`=1: new word accepted, → SEND with no gap bit.
  - LAST with `load`=0 and loop active: → SEND with the stored word.
  - LAST otherwise: → IDLE.
- Acceptance: load with `ready`=1 captures `data` and clears the counter. Load with `ready`=0 is ignored and has no side effects. Data changes at non-accepting edges are ignored.
- Bit order follows `MSB_FIRST`: shift left and take the top bit, or shift right and take the bottom bit.
- Counter counts 0..WIDTH-1 and never wraps inside a frame; it resets on every accept or loop restart.

## Timing
- Latency: load accepted at edge N puts the first bit on `dout` after edge N; bit k is valid in cycle N+1+k; the last bit is in cycle N+WIDTH.
- `done` and `ready`=1 coincide with the last-bit cycle. `dout_vld` stays high across back-to-back frames.
- Frame occupancy is exactly WIDTH cycles. Maximum throughput is one bit per clock with no inter-frame gap.
- Reset (`rst_n` low, any time, including mid-frame):
  - Effective immediately with no clock: state IDLE, `ready`=1, `dout`=IDLE_LEVEL, `dout_vld`=0, `done`=0; shift register, counter and stored word cleared.
  - A partially sent frame is discarded and is not resumed.
  - The first rising edge after `rst_n` deasserts may accept a load.
- Simultaneous `load` and `loop` in LAST: `load` wins and the new word replaces the stored word.

## Configuration
- `SEQ_GEN_LOOP_EN` defined:
  - The `loop` port and the stored-word register exist.
  - `loop`=1 sampled in LAST with no `load` restarts the same word seamlessly; `done` still pulses at the end of every repetition.
  - Deasserting `loop` ends transmission after the current repetition.
- `SEQ_GEN_LOOP_EN` undefined: no `loop` port, no stored-word register; behaviour is identical to `loop`=0.

## Test plan
- Reset: assert `rst_n`=0 mid-clock with no edge → `ready`=1, `dout`=0, `dout_vld`=0, `done`=0 immediately.
- MSB first (WIDTH=8, MSB_FIRST=1): load 8'b1010_0110 → `dout` = 1,0,1,0,0,1,1,0 in cycles N+1..N+8; `done` and `ready` high only in N+8; `dout_vld`=0 in N+9.
- LSB first (MSB_FIRST=0): load 8'h0D → `dout` = 1,0,1,1,0,0,0,0.
- Back-to-back: load 8'hA5, then load 8'h3C in its last-bit cycle → 16 contiguous bits 10100101_00111100; `dout_vld` never drops; two `done` pulses, 8 cycles apart.
- Ignored load and reset: load 8'hFF while in SEND → no effect on the current frame. Drop `rst_n` at bit 4 of 8'hF0 → outputs go to reset values at once; a later load of 8'h81 sends the full 1,0,0,0,0,0,0,1.
- Loop (with `SEQ_GEN_LOOP_EN`): load 8'h05 with `loop`=1 → continuous 00000101 repeated, one `done` per repetition; clear `loop` during repetition 3 → stream ends after repetition 3, then IDLE.
